// File: rtl/mem_copy_engine.sv
// mem_copy_engine: copies len 32-bit words from src_addr to dst_addr, one
// word every two cycles (READ then WRITE), in ascending address order.
// Optional feature: define MEM_COPY_CHECKSUM_EN to accumulate a running sum of
// every word written; without it, checksum is tied to zero.
module mem_copy_engine #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] words_done,
    output logic             mem_write,
    output logic [31:0]      address,
    output logic [31:0]      write_data,
    input  logic [31:0]      read_data,
    output logic [31:0]      checksum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [31:0]      src_ptr;
    logic [31:0]      dst_ptr;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] words_next;
    logic [31:0]      src_next;
    logic [31:0]      dst_next;

    assign words_next = words_done + LEN_W'(1);
    assign src_next   = src_ptr + 32'd4;
    assign dst_next   = dst_ptr + 32'd4;

`ifdef MEM_COPY_CHECKSUM_EN
    logic [31:0] sum_q;

    // Running sum of written words, cleared whenever a new copy is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= 32'd0;
        end else if (state == IDLE && start) begin
            sum_q <= 32'd0;
        end else if (state == WRITE) begin
            sum_q <= sum_q + write_data;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 32'd0;
`endif

    // Copy sequencer: state, pointers, counters and all bus outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            src_ptr    <= 32'd0;
            dst_ptr    <= 32'd0;
            len_q      <= '0;
            words_done <= '0;
            write_data <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_write  <= 1'b0;
            address    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    done      <= 1'b0;
                    mem_write <= 1'b0;
                    busy      <= 1'b0;
                    address   <= 32'd0;
                    if (start) begin
                        words_done <= '0;
                        if (len != '0) begin
                            src_ptr <= src_addr & 32'hFFFF_FFFC;
                            dst_ptr <= dst_addr & 32'hFFFF_FFFC;
                            len_q   <= len;
                            address <= src_addr & 32'hFFFF_FFFC;
                            busy    <= 1'b1;
                            state   <= READ;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end

                READ: begin
                    write_data <= read_data;
                    if (abort) begin
                        busy    <= 1'b0;
                        address <= 32'd0;
                        state   <= IDLE;
                    end else begin
                        address   <= dst_ptr;
                        mem_write <= 1'b1;
                        state     <= WRITE;
                    end
                end

                WRITE: begin
                    src_ptr    <= src_next;
                    dst_ptr    <= dst_next;
                    words_done <= words_next;
                    mem_write  <= 1'b0;
                    if (abort) begin
                        busy    <= 1'b0;
                        address <= 32'd0;
                        state   <= IDLE;
                    end else if (words_next == len_q) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        address <= 32'd0;
                        state   <= DONE;
                    end else begin
                        address <= src_next;
                        state   <= READ;
                    end
                end

                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    mem_write <= 1'b0;
                    address   <= 32'd0;
                    state     <= IDLE;
                end

                default: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    mem_write <= 1'b0;
                    address   <= 32'd0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: scoreboard bench for mem_copy_engine. A reference model
// predicts every memory write and done pulse; a monitor compares them.
// Checksum expectations follow MEM_COPY_CHECKSUM_EN when it is defined.
module tb_mem_copy_engine;

    localparam int LEN_W = 8;

    typedef struct {
        bit          is_done;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
        logic [31:0] count;
        logic [31:0] csum;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] words_done;
    logic             mem_write;
    logic [31:0]      address;
    logic [31:0]      write_data;
    logic [31:0]      read_data;
    logic [31:0]      checksum;

    logic [31:0] mem       [0:1023];
    logic [31:0] model_mem [0:1023];
    exp_t        exp_q[$];
    int          cyc;
    int          checks;
    int          errors;

    mem_copy_engine #(.LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .words_done (words_done),
        .mem_write  (mem_write),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .checksum   (checksum)
    );

    // Free-running clock and cycle counter used to time expected events.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Word memory seen by the engine: combinational read, write on the clock edge.
    assign read_data = mem[address[11:2]];

    always @(posedge clk) begin
        if (mem_write) mem[address[11:2]] <= write_data;
    end

    function automatic logic [31:0] expected_csum(input logic [31:0] sum);
`ifdef MEM_COPY_CHECKSUM_EN
        return sum;
`else
        return 32'd0 & sum;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: every write or done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (!busy) begin
                checkOutput("idle_address", address, 32'd0);
                checkOutput("idle_no_write", 32'(mem_write), 32'd0);
            end
            if (mem_write || done) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_event", {30'd0, done, mem_write}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("event_kind", {30'd0, done, mem_write}, e.is_done ? 32'd2 : 32'd1);
                    checkOutput("event_cycle", 32'(cyc), 32'(e.cyc));
                    if (e.is_done) begin
                        checkOutput("done_words", 32'(words_done), e.count);
                        checkOutput("done_checksum", checksum, e.csum);
                    end else begin
                        checkOutput("write_address", address, e.addr);
                        checkOutput("write_data", write_data, e.data);
                    end
                end
            end
        end
    end

    // Issue one copy; abort_at=j aborts during the j-th write (0 means no abort).
    task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst,
                                 input int n, input int abort_at);
        int          base;
        int          nw;
        logic [31:0] sp;
        logic [31:0] dp;
        logic [31:0] sum;
        logic [31:0] d;
        @(negedge clk);
        start    = 1'b1;
        abort    = 1'b0;
        src_addr = src;
        dst_addr = dst;
        len      = LEN_W'(n);
        base     = cyc + 1;
        sp       = src & 32'hFFFF_FFFC;
        dp       = dst & 32'hFFFF_FFFC;
        sum      = 32'd0;
        nw       = (abort_at > 0) ? abort_at : n;
        for (int j = 1; j <= nw; j++) begin
            d = model_mem[sp[11:2]];
            model_mem[dp[11:2]] = d;
            sum = sum + d;
            exp_q.push_back('{is_done: 1'b0, addr: dp, data: d, cyc: base + 2*j - 1,
                              count: 32'd0, csum: 32'd0});
            sp = sp + 32'd4;
            dp = dp + 32'd4;
        end
        if (abort_at == 0) begin
            exp_q.push_back('{is_done: 1'b1, addr: 32'd0, data: 32'd0, cyc: base + 2*n,
                              count: 32'(n), csum: expected_csum(sum)});
        end
        @(negedge clk);
        start    = 1'b0;
        src_addr = $urandom;
        dst_addr = $urandom;
        len      = LEN_W'($urandom);
        if (n > 0) begin
            checkOutput("first_read_address", address, src & 32'hFFFF_FFFC);
            checkOutput("busy_in_read", 32'(busy), 32'd1);
        end
        if (abort_at > 0) begin
            while (cyc < base + 2*abort_at - 1) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            repeat (3) @(negedge clk);
            checkOutput("abort_words_done", 32'(words_done), 32'(abort_at));
            checkOutput("abort_busy", 32'(busy), 32'd0);
        end else begin
            repeat (2*n + 2) @(negedge clk);
            checkOutput("final_words_done", 32'(words_done), 32'(n));
            checkOutput("final_busy", 32'(busy), 32'd0);
        end
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Watchdog so the run always ends even if the sequence stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, directed cases, then randomized copies.
    initial begin
        int n;
        int ab;
        logic [31:0] s;
        logic [31:0] t;
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        src_addr = 32'd0;
        dst_addr = 32'd0;
        len      = '0;
        for (int i = 0; i < 1024; i++) begin
            mem[i]       = $urandom | 32'd1;
            model_mem[i] = mem[i];
        end
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
        model_mem[0] = 32'h11; model_mem[1] = 32'h22; model_mem[2] = 32'h33;

        #2;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_mem_write", 32'(mem_write), 32'd0);
        checkOutput("reset_address", address, 32'd0);
        checkOutput("reset_write_data", write_data, 32'd0);
        checkOutput("reset_words_done", 32'(words_done), 32'd0);
        checkOutput("reset_checksum", checksum, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed cases");
        applyStimulus(32'h0000_0000, 32'h0000_0040, 3, 0);
        applyStimulus(32'h0000_0000, 32'h0000_0040, 0, 0);
        applyStimulus(32'h0000_0003, 32'h0000_0081, 1, 0);
        applyStimulus(32'hFFFF_FFFC, 32'h0000_0100, 2, 0);
        applyStimulus(32'h0000_0010, 32'h0000_0200, 4, 2);

        $display("[TB] reset during READ");
        @(negedge clk);
        start    = 1'b1;
        src_addr = 32'h0000_0020;
        dst_addr = 32'h0000_0300;
        len      = LEN_W'(5);
        @(negedge clk);
        start = 1'b0;
        checkOutput("pre_reset_busy", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_busy", 32'(busy), 32'd0);
        checkOutput("async_done", 32'(done), 32'd0);
        checkOutput("async_mem_write", 32'(mem_write), 32'd0);
        checkOutput("async_address", address, 32'd0);
        checkOutput("async_write_data", write_data, 32'd0);
        checkOutput("async_words_done", 32'(words_done), 32'd0);
        checkOutput("async_checksum", checksum, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(32'h0000_0014, 32'h0000_0180, 1, 0);

        $display("[TB] randomized copies");
        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(0, 12);
            s = $urandom;
            case ($urandom_range(0, 2))
                0:       t = s + 32'd4;
                1:       t = s - 32'd8;
                default: t = $urandom;
            endcase
            ab = (n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
            applyStimulus(s, t, n, ab);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
